button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 106 ++++++++++
 tb/tb_button_debouncer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchronised debouncer with press/release pulses and optional long-press
//   Ports: clock_100mhz (clock), rst_n_i (async active-low reset), buttons_i (raw levels, 1 = pressed),
//          level_o (debounced level), pressed_o / released_o / long_o (one-cycle registered pulses).
//   Macro BUTTON_LONG_PRESS_EN enables the long-press counter; otherwise long_o is tied to 0.
module button_debouncer #(
  parameter int N_CH        = 4,
  parameter int DEB_CYCLES  = 1000000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic            clock_100mhz,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] buttons_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] pressed_o,
  output logic [N_CH-1:0] released_o,
  output logic [N_CH-1:0] long_o
);
  localparam int MAX_C = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_e;
  logic [N_CH-1:0] meta_q, sync_q;
  always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= buttons_i;
      sync_q <= meta_q;
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_q, pressed_q, released_q, pressed_d, released_d, s;
    assign s = sync_q[c];
    // The entry sample moves RELEASED/PRESSED into a pending state; DEB_CYCLES further
    // agreeing samples are then counted before the change is accepted.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      case (state_q)
        RELEASED: if (s) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
        PRESS_PEND: if (!s) state_d = RELEASED;
          else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d   = PRESSED;
            pressed_d = 1'b1;
          end else if (cnt_q != CW'(MAX_C)) cnt_d = cnt_q + 1'b1;
        PRESSED: if (!s) begin
          state_d = RELEASE_PEND;
          cnt_d   = '0;
        end
        RELEASE_PEND: if (s) state_d = PRESSED;
          else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d    = RELEASED;
            released_d = 1'b1;
          end else if (cnt_q != CW'(MAX_C)) cnt_d = cnt_q + 1'b1;
        default: state_d = RELEASED;
      endcase
    end
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q    <= RELEASED;
        cnt_q      <= '0;
        level_q    <= 1'b0;
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        level_q    <= (state_d == PRESSED) || (state_d == RELEASE_PEND);
        pressed_q  <= pressed_d;
        released_q <= released_d;
      end
    end
    assign level_o[c]    = level_q;
    assign pressed_o[c]  = pressed_q;
    assign released_o[c] = released_q;
`ifdef BUTTON_LONG_PRESS_EN
    logic [CW-1:0] lc_q, lc_d;
    logic          held, long_d, long_q;
    assign held = (state_q == PRESSED) || (state_q == RELEASE_PEND);
    // Counter saturates at LONG_CYCLES so the pulse fires once per press.
    always_comb begin
      lc_d   = held ? ((lc_q == CW'(LONG_CYCLES)) ? lc_q : lc_q + 1'b1) : '0;
      long_d = held && (lc_q == CW'(LONG_CYCLES - 1));
    end
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
      if (!rst_n_i) begin
        lc_q   <= '0;
        long_q <= 1'b0;
      end else begin
        lc_q   <= lc_d;
        long_q <= long_d;
      end
    end
    assign long_o[c] = long_q;
`else
    assign long_o[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: random and directed stimulus checked every cycle against a run-length model
module tb_button_debouncer;
  localparam int N = 4, DEB = 8, LONG = 32;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] lvl_o, pr_o, rl_o, lg_o;
  always #5 clk = ~clk;
  button_debouncer #(.N_CH(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clock_100mhz(clk), .rst_n_i(rst_n), .buttons_i(btn),
    .level_o(lvl_o), .pressed_o(pr_o), .released_o(rl_o), .long_o(lg_o));
  int checks = 0, failures = 0, cyc = 0;
  logic [N-1:0] m_lvl = '0, m_pr = '0, m_rl = '0, m_lg = '0, b_s, seen;
  logic r_s;
  logic [N-1:0] dq[$];
  int run[N], lc[N], npress[N], nrel[N], nlong[N], last_pr[N], last_rl[N], last_lg[N];
  int all_pr = 0, all_rl = 0;
  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask
  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  // Model: the debouncer sees each input two edges late; a level change is accepted
  // when DEB+1 consecutive seen samples disagree with the current level.
  initial forever begin
    @(posedge clk);
    b_s = btn;
    r_s = rst_n;
    cyc++;
    #1;
    m_pr = '0;
    m_rl = '0;
    m_lg = '0;
    if (!r_s) begin
      dq.delete();
      m_lvl = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        lc[i]  = 0;
      end
    end else begin
      seen = (dq.size() == 2) ? dq[0] : '0;
      dq.push_back(b_s);
      if (dq.size() > 2) void'(dq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (m_lvl[i]) begin
          lc[i]++;
          if (lc[i] == LONG && LONG_EN) m_lg[i] = 1'b1;
        end
        if (seen[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            m_lvl[i] = seen[i];
            if (seen[i]) begin
              m_pr[i] = 1'b1;
              lc[i]   = 0;
            end else m_rl[i] = 1'b1;
            run[i] = 0;
          end
        end else run[i] = 0;
      end
    end
    chk("level", lvl_o, m_lvl);
    chk("pressed", pr_o, m_pr);
    chk("released", rl_o, m_rl);
    chk("long", lg_o, m_lg);
    for (int i = 0; i < N; i++) begin
      if (pr_o[i]) begin npress[i]++; last_pr[i] = cyc; end
      if (rl_o[i]) begin nrel[i]++;   last_rl[i] = cyc; end
      if (lg_o[i]) begin nlong[i]++;  last_lg[i] = cyc; end
    end
    if (pr_o == '1) all_pr++;
    if (rl_o == '1) all_rl++;
  end
  int e0, np;
  int tmr[N];
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", lvl_o | pr_o | rl_o | lg_o, 4'b0000);
    btn[0] = 1'b1;
    e0 = cyc + 1;
    repeat (20) @(negedge clk);
    chk_int("t1_press_latency", last_pr[0] - e0, 10);
    chk_int("t1_press_count", npress[0], 1);
    chk("t1_level", lvl_o, 4'b0001);
    btn[0] = 1'b0;
    e0 = cyc + 1;
    repeat (20) @(negedge clk);
    chk_int("t1_release_latency", last_rl[0] - e0, 10);
    chk_int("t1_release_count", nrel[0], 1);
    for (int k = 0; k < 60; k++) begin
      if (k % 7 == 0) btn[1] = ~btn[1];
      @(negedge clk);
    end
    btn[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk_int("t2_bounce_press", npress[1], 0);
    chk("t2_level", lvl_o, 4'b0000);
    btn = 4'b1111;
    repeat (20) @(negedge clk);
    chk_int("t3_all_press", all_pr, 1);
    chk("t3_level", lvl_o, 4'b1111);
    btn = 4'b0000;
    repeat (20) @(negedge clk);
    chk_int("t3_all_release", all_rl, 1);
    chk("t3_level_off", lvl_o, 4'b0000);
    btn[0] = 1'b1;
    repeat (15) @(negedge clk);
    btn[3] = 1'b1;
    repeat (7) @(negedge clk);
    np = npress[3];
    rst_n = 1'b0;
    #1;
    chk("t4_reset_outputs", lvl_o | pr_o | rl_o | lg_o, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    repeat (15) @(negedge clk);
    chk_int("t4_press_latency", last_pr[3] - e0, 10);
    chk_int("t4_press_count", npress[3], np + 1);
    btn = 4'b0000;
    repeat (15) @(negedge clk);
    btn[2] = 1'b1;
    repeat (50) @(negedge clk);
    btn[2] = 1'b0;
    repeat (15) @(negedge clk);
    if (LONG_EN) begin
      chk_int("t5_long_delay", last_lg[2] - last_pr[2], 32);
      chk_int("t5_long_count", nlong[2], 1);
    end else chk_int("t5_long_off", nlong[2], 0);
    for (int i = 0; i < N; i++) tmr[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          btn[i] = ~btn[i];
          tmr[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 14);
        end else tmr[i]--;
      end
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    btn = '0;
    repeat (20) @(negedge clk);
    chk("final_level", lvl_o, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
